// File: rtl/md_pkg.sv
// Shared types and constants for the market-data frame controller.
// Optional CSUM checking is enabled with `define MD_CSUM_CHECK_EN.
package md_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        SYM,
        PRC,
        QTY,
        CSUM,
        EOF,
        DISCARD
    } md_state_e;

    localparam logic [7:0] MD_SOF = 8'hFB;
    localparam logic [7:0] MD_EOF = 8'hFD;

    typedef struct packed {
        logic [31:0] symbol;
        logic [31:0] price;
        logic [31:0] quantity;
    } md_msg_t;

    function automatic logic [31:0] md_csum(md_msg_t m);
        return m.symbol ^ m.price ^ m.quantity;
    endfunction

endpackage

// File: rtl/md_sat_counter.sv
// Saturating up-counter used for the frame statistics.
// Holds at all-ones instead of wrapping.
module md_sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/md_frame_ctrl.sv
// XGMII market-data frame parser with a one-deep output slot.
// Define MD_CSUM_CHECK_EN to turn the CSUM beat into a real check.
module md_frame_ctrl
    import md_pkg::*;
#(
    parameter int          DATA_WIDTH = 64,
    parameter logic [7:0]  MSG_TYPE   = 8'h01,
    parameter logic [15:0] MSG_LEN    = 16'h0020
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DATA_WIDTH-1:0]   xgmii_rxd,
    input  logic [DATA_WIDTH/8-1:0] xgmii_rxc,
    output logic [31:0]             symbol,
    output logic [31:0]             price,
    output logic [31:0]             quantity,
    output logic                    msg_valid,
    input  logic                    msg_ready,
    output logic [31:0]             total_packets,
    output logic [31:0]             error_packets,
    output logic [15:0]             overflow_packets
);

    localparam int CW = DATA_WIDTH / 8;
    localparam logic [CW-1:0] CTL_LANE0 = CW'(1);

    md_state_e state, state_n;
    md_msg_t   cap, held;

    logic       is_sof, is_fd, in_body, hdr_ok;
    logic [2:0] cap_en;
    logic       csum_bad, csum_err;
    logic       frame_end, frame_err, msg_good, slot_free;
    logic       unused_rxd;

    assign is_sof  = (xgmii_rxc == CTL_LANE0) && (xgmii_rxd[7:0] == MD_SOF);
    assign is_fd   = (xgmii_rxc == CTL_LANE0) && (xgmii_rxd[7:0] == MD_EOF);
    assign in_body = state inside {HDR, SYM, PRC, QTY, CSUM};
    assign hdr_ok  = (xgmii_rxd[23:16] == MSG_TYPE) &&
                     (xgmii_rxd[15:0] == MSG_LEN);

    assign unused_rxd = ^xgmii_rxd[DATA_WIDTH-1:32];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = state;
        cap_en    = 3'b000;
        csum_bad  = 1'b0;
        frame_end = 1'b0;
        frame_err = 1'b0;
        msg_good  = 1'b0;
        // Any control lane mid-frame aborts; a SOF restarts immediately.
        if (in_body && (xgmii_rxc != '0)) begin
            frame_end = 1'b1;
            frame_err = 1'b1;
            state_n   = is_sof ? HDR : IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (is_sof) state_n = HDR;
                end
                HDR: begin
                    state_n = hdr_ok ? SYM : DISCARD;
                end
                SYM: begin
                    cap_en[2] = 1'b1;
                    state_n   = PRC;
                end
                PRC: begin
                    cap_en[1] = 1'b1;
                    state_n   = QTY;
                end
                QTY: begin
                    cap_en[0] = 1'b1;
                    state_n   = CSUM;
                end
                CSUM: begin
`ifdef MD_CSUM_CHECK_EN
                    csum_bad = (xgmii_rxd[31:0] != md_csum(cap));
`else
                    csum_bad = 1'b0;
`endif
                    state_n  = EOF;
                end
                EOF: begin
                    if (is_fd) begin
                        frame_end = 1'b1;
                        frame_err = csum_err;
                        msg_good  = !csum_err;
                        state_n   = IDLE;
                    end else begin
                        state_n = DISCARD;
                    end
                end
                DISCARD: begin
                    if (is_fd || is_sof) begin
                        frame_end = 1'b1;
                        frame_err = 1'b1;
                        state_n   = is_sof ? HDR : IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap      <= '0;
            csum_err <= 1'b0;
        end else begin
            if (cap_en[2]) cap.symbol   <= xgmii_rxd[31:0];
            if (cap_en[1]) cap.price    <= xgmii_rxd[31:0];
            if (cap_en[0]) cap.quantity <= xgmii_rxd[31:0];
            if (state == CSUM) csum_err <= csum_bad;
        end
    end

    assign slot_free = !msg_valid || msg_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held      <= '0;
            msg_valid <= 1'b0;
        end else if (msg_good && slot_free) begin
            held      <= cap;
            msg_valid <= 1'b1;
        end else if (msg_valid && msg_ready) begin
            msg_valid <= 1'b0;
        end
    end

    assign symbol   = held.symbol;
    assign price    = held.price;
    assign quantity = held.quantity;

    md_sat_counter #(.WIDTH(32)) u_total (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (frame_end),
        .count (total_packets)
    );

    md_sat_counter #(.WIDTH(32)) u_error (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (frame_end && frame_err),
        .count (error_packets)
    );

    md_sat_counter #(.WIDTH(16)) u_ovf (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (msg_good && !slot_free),
        .count (overflow_packets)
    );

endmodule

// File: doc/md_frame_ctrl.md
MD_FRAME_CTRL -- requirements
Module: md_frame_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, XGMII lane width in bits.
REQ-002 SHALL have parameter MSG_TYPE, default 8'h01, the only accepted message type.
REQ-003 SHALL have parameter MSG_LEN, default 16'h0020, the only accepted payload length.
REQ-004 SHALL have port clk, input, 1, single clock for all logic.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port xgmii_rxd, input, DATA_WIDTH, receive data.
REQ-007 SHALL have port xgmii_rxc, input, DATA_WIDTH/8, receive control lanes.
REQ-008 SHALL have ports symbol, price and quantity, each output, 32, the fields of the held message.
REQ-009 SHALL have port msg_valid, output, 1, held message is valid.
REQ-010 SHALL have port msg_ready, input, 1, the consumer accepts the message.
REQ-011 SHALL have ports total_packets and error_packets, each output, 32, frame statistics.
REQ-012 SHALL have port overflow_packets, output, 16, good messages dropped because the output slot was occupied.

Function
REQ-013 SHALL run FSM IDLE, HDR, SYM, PRC, QTY, CSUM, EOF, DISCARD, advancing one state per clk.
REQ-014 SHALL leave IDLE for HDR only when xgmii_rxc==8'h01 and xgmii_rxd[7:0]==8'hFB.
REQ-015 SHALL, in HDR, with rxc==0, check rxd[23:16]==MSG_TYPE and rxd[15:0]==MSG_LEN, and on mismatch flag an error and go to DISCARD.
REQ-016 SHALL capture rxd[31:0] as symbol in SYM, as price in PRC, and as quantity in QTY.
REQ-017 SHALL, in CSUM, compare rxd[31:0] with symbol^price^quantity and record any mismatch.
REQ-018 SHALL, in EOF, require rxc==8'h01 and rxd[7:0]==8'hFD; any other EOF beat is an error, and the FSM then goes to DISCARD.
REQ-019 SHALL treat any rxc!=0 in states HDR through CSUM as an error (abort). The FSM goes to HDR if that beat is a valid SOF, otherwise to IDLE.
REQ-020 SHALL stay in DISCARD until an FD beat (then IDLE) or an FB beat (then HDR).
REQ-021 SHALL increment total_packets once per SOF-started frame that ends by EOF, abort or DISCARD exit.
REQ-022 SHALL increment error_packets once per frame that has one or more errors, so error_packets never exceeds total_packets.
REQ-023 SHALL, on a good EOF beat sampled at edge N, assert msg_valid after edge N with the captured fields, if the output slot is free.
REQ-024 SHALL treat the slot as free when msg_valid==0, or when msg_valid && msg_ready on edge N; in that case the new message replaces the old one.
REQ-025 SHALL, when the slot is not free, drop the new message, increment overflow_packets, and leave the held message unchanged.
REQ-026 SHALL clear msg_valid on a handshake (msg_valid && msg_ready) when no new message loads on the same edge.
REQ-027 SHALL hold symbol, price and quantity stable while msg_valid && !msg_ready.
REQ-028 SHALL make all counters saturate at their maximum value and never wrap.

Reset
REQ-029 SHALL, while rst_n==0, put the FSM in IDLE and drive msg_valid=0, symbol/price/quantity=0 and all counters=0.
REQ-030 SHALL discard a frame in progress at reset without counting it, and SHALL need a new SOF after rst_n rises.

Configuration
REQ-031 SHALL, when macro MD_CSUM_CHECK_EN is defined, perform the check in REQ-017; otherwise the CSUM beat is consumed but never causes an error.

Structure
REQ-032 SHALL take the FSM state enum, the SOF (8'hFB) and EOF (8'hFD) constants, and a packed md_msg_t {symbol, price, quantity} from package md_pkg.
REQ-033 SHALL build each statistics counter from sub-module md_sat_counter (parameterised width, increment enable, saturation), instantiated three times.

Verification
REQ-034 SHALL check: good frame AAPL/0x186A0/0xC8 with correct XOR, msg_ready=1 -> msg_valid one cycle after EOF, total=1, error=0.
REQ-035 SHALL check: CSUM beat XOR'd with 0xFF and MD_CSUM_CHECK_EN defined -> no msg_valid, total=1, error=1; without the macro -> message delivered, error=0.
REQ-036 SHALL check: header length 16'h0010 -> DISCARD until FD, error=1, next good frame delivered normally.
REQ-037 SHALL check: msg_ready=0 and two good back-to-back frames -> first message held, overflow=1; then msg_ready pulses on the edge of the third EOF -> third message replaces the first.
REQ-038 SHALL check: SOF injected during the PRC beat -> first frame counted as error, second frame parsed completely, total=2, error=1.
REQ-039 SHALL check: rst_n asserted during the QTY beat -> all outputs zero immediately, no counter change after release until the next SOF.
